// File: rtl/mc_pkg.sv
// Shared encodings for the mc_control multi-cycle controller:
// state encoding, instruction fields, ALU operation codes and branch rules.
package mc_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FN_W       = 6;
  localparam int unsigned ALU_BASE_W = 4;
  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_IMM,
    CL_LW,
    CL_SW,
    CL_BRANCH,
    CL_J,
    CL_JR,
    CL_JAL
  } iclass_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_BGT   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_BLE   = 6'b100101;
  localparam logic [OP_W-1:0] OP_BGE   = 6'b100110;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BLT   = 6'b110000;

  localparam logic [FN_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [FN_W-1:0] FN_JR   = 6'b001001;
  localparam logic [FN_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FN_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FN_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FN_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;

  localparam logic [ALU_BASE_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_BASE_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_BASE_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_BASE_W-1:0] ALU_SUB  = 4'b0011;
  localparam logic [ALU_BASE_W-1:0] ALU_NOR  = 4'b0100;
  localparam logic [ALU_BASE_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [ALU_BASE_W-1:0] ALU_SLT  = 4'b0110;
  localparam logic [ALU_BASE_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_BASE_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_BASE_W-1:0] ALU_SUBU = 4'b1001;
  localparam logic [ALU_BASE_W-1:0] ALU_ADDU = 4'b1011;

  // Branch condition from the ALU compare flags (zero: rs==rt, neg: rs<rt signed).
  function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic zero,
                                        input logic neg);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = !zero;
      OP_BGT:  taken = !zero && !neg;
      OP_BLT:  taken = neg;
      OP_BLE:  taken = zero || neg;
      OP_BGE:  taken = !neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: maps the latched opcode/funct to an ALU code,
// an instruction class and a legal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]       opcode,
  input  logic [FN_W-1:0]       funct,
  output logic [ALU_BASE_W-1:0] aluop,
  output iclass_e               iclass,
  output logic                  legal
);

  always_comb begin
    aluop  = ALU_AND;
    iclass = CL_RTYPE;
    legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_ADDU: aluop = ALU_ADDU;
          FN_SUB:  aluop = ALU_SUB;
          FN_SUBU: aluop = ALU_SUBU;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_XOR:  aluop = ALU_XOR;
          FN_NOR:  aluop = ALU_NOR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLL:  aluop = ALU_SLL;
          FN_SRL:  aluop = ALU_SRL;
          FN_JR:   iclass = CL_JR;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        iclass = CL_IMM;
        aluop  = ALU_ADD;
      end
      OP_ANDI: begin
        iclass = CL_IMM;
        aluop  = ALU_AND;
      end
      OP_ORI: begin
        iclass = CL_IMM;
        aluop  = ALU_OR;
      end
      OP_LW: begin
        iclass = CL_LW;
        aluop  = ALU_ADD;
      end
      OP_SW: begin
        iclass = CL_SW;
        aluop  = ALU_ADD;
      end
      OP_BEQ, OP_BNE, OP_BGT, OP_BLT, OP_BLE, OP_BGE: begin
        iclass = CL_BRANCH;
        aluop  = ALU_SUB;
      end
      OP_J:    iclass = CL_J;
      OP_JAL:  iclass = CL_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle processor control FSM: fetch/decode/exec/mem/writeback sequencing,
// memory wait timeout with sticky fault, and a retired-instruction counter.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RET_W       = 16
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               Run,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FN_W-1:0]    funct,
  input  logic               mem_ready,
  input  logic               zero,
  input  logic               neg,
  output logic               pc_write,
  output logic               ir_write,
  output logic               Regwrite,
  output logic               Aluscr,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               MemtoReg,
  output logic               rt_or_rd,
  output logic               jump,
  output logic               jal,
  output logic               jr,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [STATE_W-1:0] state,
  output logic               fault,
  output logic [RET_W-1:0]   retired
);

  state_e                  state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [FN_W-1:0]         funct_q, funct_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [RET_W-1:0]        retired_q, retired_d;
  logic                    started_q, started_d;

  logic [ALU_BASE_W-1:0]   dec_aluop;
  iclass_e                 dec_class;
  logic                    dec_legal;
  logic                    wait_expired_c;
  state_e                  boundary_st_c;

  mc_decode u_decode (
    .opcode (op_q),
    .funct  (funct_q),
    .aluop  (dec_aluop),
    .iclass (dec_class),
    .legal  (dec_legal)
  );

  assign wait_expired_c = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  // Run only matters where one instruction ends and the next would begin.
  assign boundary_st_c  = Run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    wait_cnt_d = '0;
    retired_d  = retired_q;
    started_d  = 1'b1;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    Regwrite   = 1'b0;
    Aluscr     = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    rt_or_rd   = 1'b0;
    jump       = 1'b0;
    jal        = 1'b0;
    jr         = 1'b0;
    ALUOP      = '0;

    case (state_q)
      // started_q holds off the first fetch until one full edge after reset release.
      ST_IDLE: if (Run && started_q) state_d = ST_FETCH;

      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          op_d     = opcode;
          funct_d  = funct;
          state_d  = ST_DECODE;
        end else if (wait_expired_c) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_FAULT;

      ST_EXEC: begin
        ALUOP  = ALUOP_W'(dec_aluop);
        Aluscr = (dec_class == CL_IMM) || (dec_class == CL_LW) || (dec_class == CL_SW);
        case (dec_class)
          CL_RTYPE, CL_IMM: state_d = ST_WB;
          CL_LW, CL_SW:     state_d = ST_MEM;
          CL_BRANCH: begin
            pc_write  = branch_taken(op_q, zero, neg);
            retired_d = retired_q + RET_W'(1);
            state_d   = boundary_st_c;
          end
          CL_J: begin
            jump      = 1'b1;
            pc_write  = 1'b1;
            retired_d = retired_q + RET_W'(1);
            state_d   = boundary_st_c;
          end
          CL_JR: begin
            jr        = 1'b1;
            pc_write  = 1'b1;
            retired_d = retired_q + RET_W'(1);
            state_d   = boundary_st_c;
          end
          CL_JAL: begin
            jump     = 1'b1;
            jal      = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_WB;
          end
          default: state_d = ST_FAULT;
        endcase
      end

      ST_MEM: begin
        MemWrite = (dec_class == CL_SW);
        MemRead  = (dec_class != CL_SW);
        if (mem_ready) begin
          if (dec_class == CL_SW) begin
            retired_d = retired_q + RET_W'(1);
            state_d   = boundary_st_c;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired_c) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_WB: begin
        Regwrite  = 1'b1;
        rt_or_rd  = (dec_class == CL_RTYPE);
        MemtoReg  = (dec_class == CL_LW);
        jal       = (dec_class == CL_JAL);
        retired_d = retired_q + RET_W'(1);
        state_d   = boundary_st_c;
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      funct_q    <= '0;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      started_q  <= started_d;
    end
  end

  assign state   = state_q;
  assign fault   = (state_q == ST_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: table of instructions with a per-cycle
// expected-output scoreboard, plus hand sequences for waits, faults and resets.
module tb_mc_control;

  localparam int unsigned ALUOP_W = 6;
  localparam int unsigned RET_W   = 4;

  logic               CLOCK_50;
  logic               Reset, Run, mem_ready, zero, neg;
  logic [5:0]         opcode, funct;
  logic               pc_write, ir_write, Regwrite, Aluscr, MemWrite, MemRead;
  logic               MemtoReg, rt_or_rd, jump, jal, jr, fault;
  logic [ALUOP_W-1:0] ALUOP;
  logic [2:0]         state;
  logic [RET_W-1:0]   retired;

  mc_control #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(15), .RET_W(RET_W)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .Run(Run), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero), .neg(neg), .pc_write(pc_write),
    .ir_write(ir_write), .Regwrite(Regwrite), .Aluscr(Aluscr), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .rt_or_rd(rt_or_rd), .jump(jump),
    .jal(jal), .jr(jr), .ALUOP(ALUOP), .state(state), .fault(fault), .retired(retired)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [2:0]         st;
    logic               pc_write, ir_write, Regwrite, Aluscr, MemWrite, MemRead;
    logic               MemtoReg, rt_or_rd, jump, jal, jr, fault;
    logic [ALUOP_W-1:0] aluop;
  } ctl_t;
  localparam int unsigned CTL_W = $bits(ctl_t);

  typedef struct packed {
    ctl_t val;
    ctl_t care;
  } exp_t;

  typedef enum logic [2:0] {P_ALU, P_LW, P_SW, P_BR, P_J, P_JR, P_JAL} path_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       n;
    logic [3:0] alu;
    logic       scr;
    path_e      path;
    logic       taken;
    logic       rd;
  } vec_t;

  exp_t           exp_q[$];
  vec_t           vecs[$];
  int             n_cmp  = 0;
  int             n_fail = 0;
  logic [RET_W-1:0] exp_ret;

  function automatic ctl_t sample();
    ctl_t c;
    c.st = state;        c.pc_write = pc_write; c.ir_write = ir_write;
    c.Regwrite = Regwrite; c.Aluscr = Aluscr;   c.MemWrite = MemWrite;
    c.MemRead = MemRead; c.MemtoReg = MemtoReg; c.rt_or_rd = rt_or_rd;
    c.jump = jump;       c.jal = jal;           c.jr = jr;
    c.fault = fault;     c.aluop = ALUOP;
    return c;
  endfunction

  function automatic ctl_t idle_ctl(input logic [2:0] s);
    ctl_t c;
    c       = '0;
    c.st    = s;
    c.fault = (s == 3'd7);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cyc(input string name, input ctl_t act, input ctl_t exp, input ctl_t care);
    logic [CTL_W-1:0] a, e, m;
    a = act; e = exp; m = care;
    n_cmp++;
    if (((a ^ e) & m) != '0) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h care %h (t=%0t)", name, a, e, m, $time);
    end
  endtask

  task automatic push_exp(input ctl_t v, input ctl_t c);
    exp_t x;
    x.val  = v;
    x.care = c;
    exp_q.push_back(x);
  endtask

  // Expected per-cycle outputs for one instruction with mem_ready held high.
  task automatic push_instr(input vec_t v);
    ctl_t e, all, cm;
    all = '1;
    e = '0; e.st = 3'd1; e.MemRead = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    push_exp(e, all);
    e = '0; e.st = 3'd2;
    push_exp(e, all);
    e = '0; e.st = 3'd3; e.aluop = ALUOP_W'(v.alu); e.Aluscr = v.scr;
    cm = all;
    case (v.path)
      P_BR:  e.pc_write = v.taken;
      P_J:   begin e.jump = 1'b1; e.pc_write = 1'b1; end
      P_JR:  begin e.jr = 1'b1; e.pc_write = 1'b1; end
      P_JAL: begin e.jump = 1'b1; e.jal = 1'b1; e.pc_write = 1'b1; end
      default: ;
    endcase
    if (v.path == P_J || v.path == P_JR || v.path == P_JAL) begin
      cm.aluop  = '0;
      cm.Aluscr = 1'b0;
    end
    push_exp(e, cm);
    case (v.path)
      P_LW: begin
        e = '0; e.st = 3'd4; e.MemRead = 1'b1;  push_exp(e, all);
        e = '0; e.st = 3'd5; e.Regwrite = 1'b1; e.MemtoReg = 1'b1; push_exp(e, all);
      end
      P_SW: begin
        e = '0; e.st = 3'd4; e.MemWrite = 1'b1; push_exp(e, all);
      end
      P_ALU: begin
        e = '0; e.st = 3'd5; e.Regwrite = 1'b1; e.rt_or_rd = v.rd; push_exp(e, all);
      end
      P_JAL: begin
        cm = all; cm.rt_or_rd = 1'b0;
        e = '0; e.st = 3'd5; e.Regwrite = 1'b1; e.jal = 1'b1; push_exp(e, cm);
      end
      default: ;
    endcase
  endtask

  task automatic wait_fetch(input string name);
    int k;
    k = 0;
    while (state != 3'd1 && k < 10) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (state != 3'd1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: FETCH not reached, state=%0d", name, state);
    end
  endtask

  // Entered at a negedge while in FETCH; leaves at the negedge after the last cycle.
  task automatic run_instr(input int idx, input vec_t v, input logic drop_run);
    exp_t x;
    int   c;
    opcode = v.op; funct = v.fn; zero = v.z; neg = v.n; mem_ready = 1'b1;
    push_instr(v);
    #1;
    c = 0;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check_cyc($sformatf("vec%0d_cyc%0d", idx, c), sample(), x.val, x.care);
      @(negedge CLOCK_50);
      if (drop_run) Run = 1'b0;
      c++;
    end
    exp_ret = exp_ret + RET_W'(1);
    check($sformatf("vec%0d_retired", idx), 32'(retired), 32'(exp_ret));
  endtask

  task automatic do_reset(input string name);
    Reset = 1'b0;
    #1;
    check_cyc({name, "_state"}, sample(), idle_ctl(3'd0), '1);
    check({name, "_retired"}, 32'(retired), 32'd0);
    @(negedge CLOCK_50);
    Reset   = 1'b1;
    exp_ret = '0;
  endtask

  task automatic illegal_seq(input string name, input logic [5:0] op, input logic [5:0] fn);
    wait_fetch({name, "_fetch"});
    opcode = op; funct = fn; mem_ready = 1'b1;
    @(negedge CLOCK_50);
    check({name, "_decode"}, 32'(state), 32'd2);
    @(negedge CLOCK_50);
    check_cyc({name, "_fault"}, sample(), idle_ctl(3'd7), '1);
    do_reset({name, "_reset"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int mem_cyc, rd_cyc;
    vec_t v;

    vecs.push_back('{6'b000000, 6'b100000, 1'b0, 1'b0, 4'b0010, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b100010, 1'b0, 1'b0, 4'b0011, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b100111, 1'b0, 1'b0, 4'b0100, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b101010, 1'b0, 1'b0, 4'b0110, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b000010, 1'b0, 1'b0, 4'b1000, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b100001, 1'b0, 1'b0, 4'b1011, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b100100, 1'b0, 1'b0, 4'b0000, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b000000, 6'b100110, 1'b0, 1'b0, 4'b0101, 1'b0, P_ALU, 1'b0, 1'b1});
    vecs.push_back('{6'b001000, 6'b000000, 1'b0, 1'b0, 4'b0010, 1'b1, P_ALU, 1'b0, 1'b0});
    vecs.push_back('{6'b001100, 6'b000000, 1'b0, 1'b0, 4'b0000, 1'b1, P_ALU, 1'b0, 1'b0});
    vecs.push_back('{6'b001101, 6'b000000, 1'b0, 1'b0, 4'b0001, 1'b1, P_ALU, 1'b0, 1'b0});
    vecs.push_back('{6'b101011, 6'b000000, 1'b0, 1'b0, 4'b0010, 1'b1, P_SW,  1'b0, 1'b0});
    vecs.push_back('{6'b100011, 6'b000000, 1'b0, 1'b0, 4'b0010, 1'b1, P_LW,  1'b0, 1'b0});
    vecs.push_back('{6'b000100, 6'b000000, 1'b1, 1'b0, 4'b0011, 1'b0, P_BR,  1'b1, 1'b0});
    vecs.push_back('{6'b000101, 6'b000000, 1'b1, 1'b0, 4'b0011, 1'b0, P_BR,  1'b0, 1'b0});
    vecs.push_back('{6'b001111, 6'b000000, 1'b0, 1'b0, 4'b0011, 1'b0, P_BR,  1'b1, 1'b0});
    vecs.push_back('{6'b001111, 6'b000000, 1'b1, 1'b0, 4'b0011, 1'b0, P_BR,  1'b0, 1'b0});
    vecs.push_back('{6'b110000, 6'b000000, 1'b0, 1'b1, 4'b0011, 1'b0, P_BR,  1'b1, 1'b0});
    vecs.push_back('{6'b100101, 6'b000000, 1'b0, 1'b1, 4'b0011, 1'b0, P_BR,  1'b1, 1'b0});
    vecs.push_back('{6'b100101, 6'b000000, 1'b0, 1'b0, 4'b0011, 1'b0, P_BR,  1'b0, 1'b0});
    vecs.push_back('{6'b100110, 6'b000000, 1'b0, 1'b1, 4'b0011, 1'b0, P_BR,  1'b0, 1'b0});
    vecs.push_back('{6'b100110, 6'b000000, 1'b1, 1'b0, 4'b0011, 1'b0, P_BR,  1'b1, 1'b0});
    vecs.push_back('{6'b000010, 6'b000000, 1'b0, 1'b0, 4'b0000, 1'b0, P_J,   1'b0, 1'b0});
    vecs.push_back('{6'b000000, 6'b001001, 1'b0, 1'b0, 4'b0000, 1'b0, P_JR,  1'b0, 1'b0});
    vecs.push_back('{6'b000011, 6'b000000, 1'b0, 1'b0, 4'b0000, 1'b0, P_JAL, 1'b0, 1'b0});

    Reset = 1'b0; Run = 1'b0; opcode = '0; funct = '0;
    mem_ready = 1'b0; zero = 1'b0; neg = 1'b0; exp_ret = '0;
    repeat (3) @(negedge CLOCK_50);
    check_cyc("reset_outputs", sample(), idle_ctl(3'd0), '1);
    check("reset_retired", 32'(retired), 32'd0);

    // Release reset with Run already high: no fetch on the first edge.
    Reset = 1'b1; Run = 1'b1;
    @(negedge CLOCK_50);
    check("first_edge_idle", 32'(state), 32'd0);
    wait_fetch("startup");

    for (int i = 0; i < vecs.size(); i++) begin
      wait_fetch($sformatf("vec%0d_fetch", i));
      run_instr(i, vecs[i], 1'b0);
    end

    // Run dropped mid-instruction: the instruction completes, then IDLE.
    v = vecs[11];
    run_instr(100, v, 1'b1);
    check("sw_drop_run_idle", 32'(state), 32'd0);
    Run = 1'b1;
    wait_fetch("after_sw_drop");
    v = vecs[12];
    run_instr(101, v, 1'b1);
    check("lw_drop_run_idle", 32'(state), 32'd0);
    Run = 1'b1;
    wait_fetch("after_lw_drop");

    // lw with mem_ready late by three cycles in MEM.
    opcode = 6'b100011; funct = '0; mem_ready = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("lw_delay_exec_aluop", 32'(ALUOP), 32'd2);
    mem_ready = 1'b0;
    mem_cyc = 0; rd_cyc = 0;
    for (int k = 0; k < 12 && state != 3'd5; k++) begin
      @(negedge CLOCK_50);
      if (state == 3'd4) begin
        mem_cyc++;
        if (MemRead) rd_cyc++;
        if (mem_cyc == 4) mem_ready = 1'b1;
      end
    end
    check("lw_delay_memread_cycles", 32'(rd_cyc), 32'd4);
    check("lw_delay_wb_state", 32'(state), 32'd5);
    check("lw_delay_memtoreg", 32'(MemtoReg), 32'd1);
    check("lw_delay_regwrite", 32'(Regwrite), 32'd1);
    @(negedge CLOCK_50);
    exp_ret = exp_ret + RET_W'(1);
    check("lw_delay_retired", 32'(retired), 32'(exp_ret));
    check("lw_delay_next_fetch", 32'(state), 32'd1);

    // FETCH starved of mem_ready: fault after exactly the timeout.
    mem_ready = 1'b0;
    repeat (14) @(negedge CLOCK_50);
    check("timeout_still_fetch", 32'(state), 32'd1);
    @(negedge CLOCK_50);
    check_cyc("timeout_fault", sample(), idle_ctl(3'd7), '1);
    mem_ready = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check_cyc("fault_sticky", sample(), idle_ctl(3'd7), '1);
    do_reset("fault_exit");

    illegal_seq("illegal_op", 6'b111111, 6'b000000);
    illegal_seq("illegal_funct", 6'b000000, 6'b111111);

    // Asynchronous reset while sw is waiting in MEM.
    wait_fetch("sw_reset_fetch");
    opcode = 6'b101011; funct = '0; mem_ready = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    mem_ready = 1'b0;
    @(negedge CLOCK_50);
    check("sw_mid_mem_state", 32'(state), 32'd4);
    check("sw_mid_mem_memwrite", 32'(MemWrite), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check_cyc("sw_async_reset", sample(), idle_ctl(3'd0), '1);
    @(negedge CLOCK_50);
    Reset = 1'b1; exp_ret = '0; mem_ready = 1'b1;

    // Seventeen addi back to back: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      wait_fetch($sformatf("addi%0d_fetch", i));
      run_instr(200 + i, vecs[8], 1'b0);
    end
    check("retired_wrap", 32'(retired), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
